// File: rtl/systolic_feed_ctrl_pkg.sv
// Shared types and width helpers for the systolic operand feed controller.
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_e;

  // Row lanes walk along a row of the store; column lanes walk down a column.
  typedef enum logic {LANE_ROW, LANE_COL} lane_mode_e;

  function automatic int clog2_min1(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

  function automatic int aw_f(input int max_dim);
    return clog2_min1(max_dim * max_dim);
  endfunction

  function automatic int dw_f(input int max_dim);
    return clog2_min1(max_dim + 1);
  endfunction

  function automatic int cw_f(input int max_dim);
    return clog2_min1(3 * max_dim);
  endfunction

  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/systolic_feed_ctrl_lane_skew.sv
// Per-lane diagonal skew: decides whether a lane is live at feed step cnt
// and forms its row-major store address (stride MAX_DIM).
module systolic_lane_skew
  import systolic_pkg::*;
#(
  parameter int MAX_DIM = 4,
  parameter int AW      = aw_f(MAX_DIM),
  parameter int DW      = dw_f(MAX_DIM),
  parameter int CW      = cw_f(MAX_DIM)
) (
  input  logic [CW-1:0] cnt,
  input  logic [DW-1:0] lane,
  input  logic [DW-1:0] dim,
  input  logic          feed,
  input  lane_mode_e    mode,
  output logic          vld,
  output logic [AW-1:0] addr
);

  localparam logic [AW-1:0] STRIDE = AW'(MAX_DIM);

  logic [CW-1:0] lane_c, dim_c, k;
  logic [AW-1:0] lane_a, k_a;

  assign lane_c = CW'(lane);
  assign dim_c  = CW'(dim);
  // k is the inner-product index this lane carries at step cnt
  assign k      = cnt - lane_c;
  assign lane_a = AW'(lane);
  assign k_a    = AW'(k);

  assign vld  = feed && (lane < dim) && (cnt >= lane_c) && (k < dim_c);
  assign addr = !vld ? '0 :
                (mode == LANE_ROW) ? lane_a * STRIDE + k_a : k_a * STRIDE + lane_a;

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Operand sequencer for a MAX_DIM x MAX_DIM systolic array: skewed A/B feed,
// drain, done. Optional macro SYSTOLIC_FEED_TRANSPOSE_B_EN reads B transposed.
module systolic_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  MAX_DIM    = 4,
  localparam int AW         = aw_f(MAX_DIM),
  localparam int DW         = dw_f(MAX_DIM),
  localparam int CW         = cw_f(MAX_DIM)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [DW-1:0]                 dim_i,
`ifdef SYSTOLIC_FEED_TRANSPOSE_B_EN
  input  logic                          trans_b_i,
`endif
  output logic [MAX_DIM*AW-1:0]         a_addr_o,
  input  logic [MAX_DIM*DATA_WIDTH-1:0] a_data_i,
  output logic [MAX_DIM*AW-1:0]         b_addr_o,
  input  logic [MAX_DIM*DATA_WIDTH-1:0] b_data_i,
  output logic [MAX_DIM*DATA_WIDTH-1:0] left_o,
  output logic [MAX_DIM*DATA_WIDTH-1:0] up_o,
  output logic                          array_clr_o,
  output logic                          array_en_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o
);

  state_e                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [DW-1:0]                 dim_q;
  logic                          trans_q, trans_in;
  logic                          clr_q, err_q;
  logic                          start_ok, start_bad, dim_ok, feed;
  logic [CW-1:0]                 last_feed, last_drain;
  logic [MAX_DIM-1:0]            a_vld, b_vld;
  logic [MAX_DIM*DATA_WIDTH-1:0] left_d, up_d;
  lane_mode_e                    b_mode;

`ifdef SYSTOLIC_FEED_TRANSPOSE_B_EN
  assign trans_in = trans_b_i;
`else
  assign trans_in = 1'b0;
`endif

  assign dim_ok     = (dim_i != '0) && (dim_i <= DW'(MAX_DIM));
  assign feed       = (state_q == FEED);
  assign last_feed  = CW'({dim_q, 1'b0}) - CW'(2);
  assign last_drain = CW'(dim_q) - CW'(1);
  // Transposed B walks a row of the store, same pattern as the A side
  assign b_mode     = trans_q ? LANE_ROW : LANE_COL;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    unique case (state_q)
      IDLE: if (start_i) begin
        if (dim_ok) begin
          state_d  = FEED;
          cnt_d    = '0;
          start_ok = 1'b1;
        end else begin
          start_bad = 1'b1;
        end
      end
      FEED: if (cnt_q == last_feed) begin
        state_d = DRAIN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      DRAIN: if (cnt_q == last_drain) begin
        state_d = DONE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  for (genvar g = 0; g < MAX_DIM; g++) begin : g_lane
    systolic_lane_skew #(.MAX_DIM(MAX_DIM), .AW(AW), .DW(DW), .CW(CW)) u_a (
      .cnt (cnt_q), .lane(DW'(g)), .dim(dim_q), .feed(feed), .mode(LANE_ROW),
      .vld (a_vld[g]), .addr(a_addr_o[lane_lo(g, AW) +: AW])
    );
    systolic_lane_skew #(.MAX_DIM(MAX_DIM), .AW(AW), .DW(DW), .CW(CW)) u_b (
      .cnt (cnt_q), .lane(DW'(g)), .dim(dim_q), .feed(feed), .mode(b_mode),
      .vld (b_vld[g]), .addr(b_addr_o[lane_lo(g, AW) +: AW])
    );
  end

  always_comb begin
    left_d = '0;
    up_d   = '0;
    for (int i = 0; i < MAX_DIM; i++) begin
      if (a_vld[i]) left_d[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH] = a_data_i[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH];
      if (b_vld[i]) up_d[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH]   = b_data_i[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dim_q   <= '0;
      trans_q <= 1'b0;
      clr_q   <= 1'b0;
      err_q   <= 1'b0;
      left_o  <= '0;
      up_o    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start_ok) begin
        dim_q   <= dim_i;
        trans_q <= trans_in;
      end
      clr_q  <= start_ok;
      err_q  <= start_bad;
      left_o <= left_d;
      up_o   <= up_d;
    end
  end

  assign array_clr_o = clr_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q == FEED) || (state_q == DRAIN);
  assign array_en_o  = busy_o;
  assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: directed runs with random operand stores,
// checked against a cycle-indexed reference and an external PE array model.
module tb_systolic_feed_ctrl;
  import systolic_pkg::*;

  localparam int N  = 4;
  localparam int DWD = 32;
  localparam int AW = 4;
  localparam int DW = 3;

  logic             clk_i = 1'b0;
  logic             rst_i, start_i, trans_b;
  logic [DW-1:0]    dim_i;
  logic [N*AW-1:0]  a_addr_o, b_addr_o;
  logic [N*DWD-1:0] a_data_i, b_data_i, left_o, up_o;
  logic             array_clr_o, array_en_o, busy_o, done_o, err_o;

  logic [31:0] a_mem [N*N];
  logic [31:0] b_mem [N*N];
  logic [31:0] pa [N][N];
  logic [31:0] pb [N][N];
  logic [31:0] acc [N][N];

  int checks = 0;
  int passed = 0;

  always #5 clk_i = ~clk_i;

  always_comb begin
    a_data_i = '0;
    b_data_i = '0;
    for (int l = 0; l < N; l++) begin
      a_data_i[l*DWD +: DWD] = a_mem[a_addr_o[l*AW +: AW]];
      b_data_i[l*DWD +: DWD] = b_mem[b_addr_o[l*AW +: AW]];
    end
  end

  systolic_feed_ctrl #(.DATA_WIDTH(DWD), .MAX_DIM(N)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .dim_i      (dim_i),
`ifdef SYSTOLIC_FEED_TRANSPOSE_B_EN
    .trans_b_i  (trans_b),
`endif
    .a_addr_o   (a_addr_o),
    .a_data_i   (a_data_i),
    .b_addr_o   (b_addr_o),
    .b_data_i   (b_data_i),
    .left_o     (left_o),
    .up_o       (up_o),
    .array_clr_o(array_clr_o),
    .array_en_o (array_en_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  task automatic chk_vec(input string tag, input int n, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
  endtask

  task automatic chk_bit(input string tag, input int n, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s n=%0d observed=%0b expected=%0b", tag, n, obs, exp);
  endtask

  task automatic chk_int(input string tag, input int n, input int obs, input int exp);
    checks++;
    assert (obs == exp) passed++;
    else $error("FAIL %s n=%0d observed=%0d expected=%0d", tag, n, obs, exp);
  endtask

  // Store index holding B[k][c] (or B^T[k][c] when reading transposed).
  function automatic int bidx(input int k, input int c, input bit tr);
    return tr ? c*N + k : k*N + c;
  endfunction

  function automatic logic [N*AW-1:0] exp_addr(input int t, input int d, input bit is_b, input bit tr);
    logic [N*AW-1:0] v;
    v = '0;
    if (t >= 0 && t <= 2*d-2)
      for (int l = 0; l < d; l++)
        if (t-l >= 0 && t-l < d)
          v[l*AW +: AW] = AW'(is_b ? bidx(t-l, l, tr) : l*N + (t-l));
    return v;
  endfunction

  // Edge contents after edge n hold what was read during feed step n-1.
  function automatic logic [N*DWD-1:0] exp_edge(input int n, input int d, input bit is_b, input bit tr);
    logic [N*DWD-1:0] v;
    int t;
    v = '0;
    t = n - 1;
    if (t >= 0 && t <= 2*d-2)
      for (int l = 0; l < d; l++)
        if (t-l >= 0 && t-l < d)
          v[l*DWD +: DWD] = is_b ? b_mem[bidx(t-l, l, tr)] : a_mem[l*N + (t-l)];
    return v;
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < N*N; i++) begin
      a_mem[i] = $urandom_range(0, 255);
      b_mem[i] = $urandom_range(0, 255);
    end
  endtask

  // External PE grid: A flows right, B flows down, each PE accumulates a*b.
  task automatic pe_step();
    if (array_clr_o)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          pa[r][c] = '0; pb[r][c] = '0; acc[r][c] = '0;
        end
    if (array_en_o) begin
      for (int r = 0; r < N; r++)
        for (int c = N-1; c >= 0; c--)
          if (c == 0) pa[r][c] = left_o[r*DWD +: DWD];
          else        pa[r][c] = pa[r][c-1];
      for (int c = 0; c < N; c++)
        for (int r = N-1; r >= 0; r--)
          if (r == 0) pb[r][c] = up_o[c*DWD +: DWD];
          else        pb[r][c] = pb[r-1][c];
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          acc[r][c] = acc[r][c] + pa[r][c] * pb[r][c];
    end
  endtask

  // One full run; n counts edges after the start edge (n=0 is the first FEED cycle).
  task automatic run(input int d, input bit tr, input bit hold);
    int clr_n, done_n;
    logic [31:0] want;
    clr_n = 0;
    done_n = 0;
    start_i = 1'b1;
    dim_i = DW'(d);
    trans_b = tr;
    @(posedge clk_i); #1;
    if (!hold) start_i = 1'b0;
    for (int n = 0; n <= 3*d+1; n++) begin
      if (n == 3*d) start_i = 1'b0;
      pe_step();
      clr_n  += int'(array_clr_o);
      done_n += int'(done_o);
      chk_bit("busy", n, busy_o, n <= 3*d-2);
      chk_bit("en", n, array_en_o, n <= 3*d-2);
      chk_bit("clr", n, array_clr_o, n == 0);
      chk_bit("done", n, done_o, n == 3*d-1);
      chk_bit("err", n, err_o, 1'b0);
      chk_vec("a_addr", n, 128'(a_addr_o), 128'(exp_addr(n, d, 1'b0, tr)));
      chk_vec("b_addr", n, 128'(b_addr_o), 128'(exp_addr(n, d, 1'b1, tr)));
      chk_vec("left", n, left_o, exp_edge(n, d, 1'b0, tr));
      chk_vec("up", n, up_o, exp_edge(n, d, 1'b1, tr));
      @(posedge clk_i); #1;
    end
    chk_int("clr_pulses", d, clr_n, 1);
    chk_int("done_pulses", d, done_n, 1);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        want = '0;
        if (r < d && c < d)
          for (int k = 0; k < d; k++) want = want + a_mem[r*N+k] * b_mem[bidx(k, c, tr)];
        chk_vec("pe_acc", r*N+c, 128'(acc[r][c]), 128'(want));
      end
  endtask

  task automatic chk_quiet(input string tag, input int n);
    chk_bit({tag, "_busy"}, n, busy_o, 1'b0);
    chk_bit({tag, "_en"}, n, array_en_o, 1'b0);
    chk_bit({tag, "_clr"}, n, array_clr_o, 1'b0);
    chk_bit({tag, "_done"}, n, done_o, 1'b0);
    chk_vec({tag, "_addr"}, n, 128'({a_addr_o, b_addr_o}), 128'(0));
    chk_vec({tag, "_left"}, n, left_o, '0);
    chk_vec({tag, "_up"}, n, up_o, '0);
  endtask

  initial begin
    int bad_dims [2];
    int d;
    bit tr;
    bad_dims = '{0, 5};
    rst_i = 1'b1;
    start_i = 1'b0;
    dim_i = '0;
    trans_b = 1'b0;
    fill_rand();
    #1;
    chk_quiet("reset", 0);
    chk_bit("reset_err", 0, err_o, 1'b0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Out-of-range dimensions are rejected with a single err pulse.
    for (int i = 0; i < 2; i++) begin
      start_i = 1'b1;
      dim_i = DW'(bad_dims[i]);
      @(posedge clk_i); #1;
      start_i = 1'b0;
      chk_bit("rej_err", bad_dims[i], err_o, 1'b1);
      chk_bit("rej_busy", bad_dims[i], busy_o, 1'b0);
      @(posedge clk_i); #1;
      chk_bit("rej_err_clear", bad_dims[i], err_o, 1'b0);
      chk_bit("rej_idle", bad_dims[i], busy_o, 1'b0);
    end

    // A = 1..16 row-major, B = identity: the array result must reproduce A.
    for (int i = 0; i < N*N; i++) begin
      a_mem[i] = 32'(i + 1);
      b_mem[i] = (i % (N+1) == 0) ? 32'd1 : 32'd0;
    end
    run(4, 1'b0, 1'b0);

    fill_rand(); run(2, 1'b0, 1'b0);
    fill_rand(); run(1, 1'b0, 1'b0);
    fill_rand(); run(3, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) begin
      d = $urandom_range(1, N);
`ifdef SYSTOLIC_FEED_TRANSPOSE_B_EN
      tr = 1'($urandom_range(0, 1));
`else
      tr = 1'b0;
`endif
      fill_rand();
      run(d, tr, 1'($urandom_range(0, 1)));
    end

    // Reset mid-FEED clears everything without waiting for a clock edge.
    fill_rand();
    start_i = 1'b1;
    dim_i = DW'(4);
    trans_b = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (2) begin @(posedge clk_i); #1; end
    #2 rst_i = 1'b1;
    #1;
    chk_quiet("midrst", 0);
    chk_bit("midrst_err", 0, err_o, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk_i); #1;
      chk_quiet("midrst_hold", i);
      chk_bit("midrst_hold_err", i, err_o, 1'b0);
    end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    run(4, 1'b0, 1'b0);

`ifdef SYSTOLIC_FEED_TRANSPOSE_B_EN
    fill_rand(); run(3, 1'b1, 1'b0);
    fill_rand(); run(4, 1'b1, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
